// File: rtl/priority_scan_encoder_if.sv
// Valid/ready bus of the priority scan encoder: request vectors in, one index beat out per handshake.
interface priority_scan_encoder_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic [IDX_W-1:0] index_o;
  logic             last_o;
  logic             zero_o;
  logic [IDX_W:0]   beat_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, index_o, last_o, zero_o, beat_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, index_o, last_o, zero_o, beat_o
  );
endinterface

// File: rtl/priority_scan_encoder.sv
// Holds an accepted request vector and emits the index of every set bit, one beat per
// output handshake, lowest-first or highest-first.
module priority_scan_encoder #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                   clk_i,
  input logic                   rst_i,
  priority_scan_encoder_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_pending, w_pendingNext, w_emitMask;
  logic [IDX_W:0]   r_beat, w_beatNext;
  logic [IDX_W-1:0] w_index;
  logic             w_zero, w_single, w_valid, w_last, w_ready, w_accept, w_consume;

  // Later matches overwrite earlier ones, so the loop direction selects the priority.
  always_comb begin
    w_index = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (r_pending[i]) w_index = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (r_pending[i]) w_index = IDX_W'(i);
    end
    w_emitMask = '0;
    for (int i = 0; i < WIDTH; i++)
      w_emitMask[i] = (IDX_W'(i) == w_index);
  end

  assign w_zero    = (r_pending == '0);
  assign w_single  = !w_zero && ((r_pending & (r_pending - WIDTH'(1))) == '0);
  assign w_valid   = (r_state == SCAN);
  assign w_last    = w_valid && (w_zero || w_single);
  assign w_ready   = !w_valid || (w_last && bus.ready_i);
  assign w_accept  = bus.valid_i && w_ready;
  assign w_consume = w_valid && bus.ready_i;

  always_comb begin
    w_stateNext   = r_state;
    w_pendingNext = r_pending;
    w_beatNext    = r_beat;
    if (w_accept) begin
      w_stateNext   = SCAN;
      w_pendingNext = bus.data_i;
      w_beatNext    = '0;
    end else if (w_consume) begin
      w_pendingNext = r_pending & ~w_emitMask;
      w_beatNext    = r_beat + (IDX_W + 1)'(1);
      if (w_last) begin
        w_stateNext   = IDLE;
        w_pendingNext = '0;
        w_beatNext    = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_beat    <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_pending <= w_pendingNext;
      r_beat    <= w_beatNext;
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = w_valid;
  assign bus.index_o = w_valid ? w_index : '0;
  assign bus.last_o  = w_last;
  assign bus.zero_o  = w_valid && w_zero;
  assign bus.beat_o  = w_valid ? r_beat : '0;
endmodule

// File: tb/tb_priority_scan_encoder.sv
// Drives three encoder configurations from shared inputs and checks the selected one
// against a queue of expected set-bit indices.
module tb_priority_scan_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        validIn = 1'b0;
  logic        readyIn = 1'b0;
  logic [31:0] dataIn = '0;

  int sel = 0;
  int curWidth = 32;
  bit curMsb = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int expQ[$];

  logic       obsValid, obsReady, obsLast, obsZero;
  logic [4:0] obsIndex;
  logic [5:0] obsBeat;

  always #5 clk = ~clk;

  priority_scan_encoder_if #(.WIDTH(32)) ifLsb();
  priority_scan_encoder_if #(.WIDTH(32)) ifMsb();
  priority_scan_encoder_if #(.WIDTH(20)) ifW20();

  assign ifLsb.valid_i = validIn;
  assign ifLsb.ready_i = readyIn;
  assign ifLsb.data_i  = dataIn;
  assign ifMsb.valid_i = validIn;
  assign ifMsb.ready_i = readyIn;
  assign ifMsb.data_i  = dataIn;
  assign ifW20.valid_i = validIn;
  assign ifW20.ready_i = readyIn;
  assign ifW20.data_i  = dataIn[19:0];

  priority_scan_encoder #(.WIDTH(32), .MSB_FIRST(1'b0)) uLsb (.clk_i(clk), .rst_i(rst), .bus(ifLsb.slave));
  priority_scan_encoder #(.WIDTH(32), .MSB_FIRST(1'b1)) uMsb (.clk_i(clk), .rst_i(rst), .bus(ifMsb.slave));
  priority_scan_encoder #(.WIDTH(20), .MSB_FIRST(1'b0)) uW20 (.clk_i(clk), .rst_i(rst), .bus(ifW20.slave));

  // Route the configuration under test onto one set of observation signals.
  always_comb begin
    obsValid = ifLsb.valid_o;
    obsReady = ifLsb.ready_o;
    obsIndex = ifLsb.index_o;
    obsLast  = ifLsb.last_o;
    obsZero  = ifLsb.zero_o;
    obsBeat  = ifLsb.beat_o;
    case (sel)
      1: begin
        obsValid = ifMsb.valid_o;
        obsReady = ifMsb.ready_o;
        obsIndex = ifMsb.index_o;
        obsLast  = ifMsb.last_o;
        obsZero  = ifMsb.zero_o;
        obsBeat  = ifMsb.beat_o;
      end
      2: begin
        obsValid = ifW20.valid_o;
        obsReady = ifW20.ready_o;
        obsIndex = ifW20.index_o;
        obsLast  = ifW20.last_o;
        obsZero  = ifW20.zero_o;
        obsBeat  = ifW20.beat_o;
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s (cfg %0d): observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs();
    checkOutput("idleValid", 32'(obsValid), 32'd0);
    checkOutput("idleReady", 32'(obsReady), 32'd1);
    checkOutput("idleIndex", 32'(obsIndex), 32'd0);
    checkOutput("idleLast",  32'(obsLast),  32'd0);
    checkOutput("idleZero",  32'(obsZero),  32'd0);
    checkOutput("idleBeat",  32'(obsBeat),  32'd0);
  endtask

  task automatic checkIdle();
    @(negedge clk);
    validIn = 1'b0;
    readyIn = 1'($urandom_range(1));
    dataIn  = $urandom;
    #1;
    checkIdleOutputs();
  endtask

  // Reset is asserted with a vector offered, which must not be taken.
  task automatic applyReset();
    @(negedge clk);
    rst     = 1'b1;
    validIn = 1'b1;
    readyIn = 1'b1;
    dataIn  = $urandom;
    @(negedge clk);
    rst     = 1'b0;
    validIn = 1'b0;
    #1;
    checkIdleOutputs();
  endtask

  task automatic applyStimulus(input logic [31:0] vec);
    @(negedge clk);
    validIn = 1'b1;
    dataIn  = vec;
    readyIn = 1'($urandom_range(1));
    #1;
    checkOutput("acceptReady", 32'(obsReady), 32'd1);
    checkOutput("acceptValid", 32'(obsValid), 32'd0);
    @(posedge clk);
  endtask

  // Reference: every set bit within the configured width, in priority order.
  task automatic buildExp(input logic [31:0] vec);
    expQ.delete();
    for (int i = 0; i < curWidth; i++)
      if (vec[i]) begin
        if (curMsb) expQ.push_front(i);
        else        expQ.push_back(i);
      end
  endtask

  task automatic runBeats(input logic [31:0] vec, input int stallPct, input int firstStalls,
                          input int maxBeats, input bit chain, input logic [31:0] nextVec);
    int n;
    int limit;
    int stalls;
    bit stall;
    bit zeroVec;
    buildExp(vec);
    n = expQ.size();
    zeroVec = (n == 0);
    if (zeroVec) n = 1;
    limit = (maxBeats < 0) ? n : maxBeats;
    for (int b = 0; b < limit; b++) begin
      stalls = 0;
      forever begin
        @(negedge clk);
        stall = (b == 0 && stalls < firstStalls) ||
                (stalls < 3 && $urandom_range(99) < stallPct);
        readyIn = !stall;
        validIn = chain && !stall && (b == n - 1);
        dataIn  = validIn ? nextVec : $urandom;
        #1;
        checkOutput("beatValid", 32'(obsValid), 32'd1);
        checkOutput("beatIndex", 32'(obsIndex), zeroVec ? 32'd0 : 32'(expQ[b]));
        checkOutput("beatLast",  32'(obsLast),  32'(b == n - 1));
        checkOutput("beatZero",  32'(obsZero),  32'(zeroVec));
        checkOutput("beatNum",   32'(obsBeat),  32'(b));
        checkOutput("beatReady", 32'(obsReady), 32'(!stall && b == n - 1));
        @(posedge clk);
        if (!stall) break;
        stalls++;
      end
    end
  endtask

  function automatic logic [31:0] randVec();
    logic [31:0] v;
    case ($urandom_range(3))
      0:       v = '0;
      1:       v = 32'h1 << $urandom_range(curWidth - 1);
      2:       v = $urandom & $urandom;
      default: v = $urandom;
    endcase
    if (curWidth < 32) v = v & ((32'h1 << curWidth) - 32'h1);
    return v;
  endfunction

  task automatic randomPhase(input int count);
    logic [31:0] cur;
    logic [31:0] nxt;
    bit chain;
    cur = randVec();
    applyStimulus(cur);
    for (int k = 0; k < count; k++) begin
      nxt   = randVec();
      chain = 1'($urandom_range(1));
      runBeats(cur, 30, 0, -1, chain, nxt);
      if (!chain) begin
        checkIdle();
        applyStimulus(nxt);
      end
      cur = nxt;
    end
    runBeats(cur, 30, 0, -1, 1'b0, 32'h0);
    checkIdle();
  endtask

  initial begin
    $display("[TB] priority_scan_encoder bench starting");

    sel = 0; curWidth = 32; curMsb = 1'b0;
    applyReset();
    applyStimulus(32'h0000_0010);
    runBeats(32'h0000_0010, 0, 0, -1, 1'b0, 32'h0);
    checkIdle();

    applyStimulus(32'h8000_0005);
    runBeats(32'h8000_0005, 0, 0, -1, 1'b0, 32'h0);
    checkIdle();

    applyStimulus(32'h0);
    runBeats(32'h0, 0, 0, -1, 1'b1, 32'h0000_0002);
    runBeats(32'h0000_0002, 0, 0, -1, 1'b0, 32'h0);
    checkIdle();

    randomPhase(8);

    applyStimulus(32'h8000_0005);
    runBeats(32'h8000_0005, 0, 0, 2, 1'b0, 32'h0);
    applyReset();
    checkIdle();
    checkIdle();

    sel = 1; curWidth = 32; curMsb = 1'b1;
    applyReset();
    applyStimulus(32'h8000_0005);
    runBeats(32'h8000_0005, 0, 3, -1, 1'b0, 32'h0);
    checkIdle();
    randomPhase(8);

    sel = 2; curWidth = 20; curMsb = 1'b0;
    applyReset();
    applyStimulus(32'h000F_FFFF);
    runBeats(32'h000F_FFFF, 0, 0, -1, 1'b0, 32'h0);
    checkIdle();
    randomPhase(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
